// File: rtl/galaga_lib.sv
// galaga_lib: shared constants and types for the Galaga-style game blocks.
//
// Contents:
//   NE, NEM            - enemy ship count and enemy missile slot count
//   NE_W, NEM_W        - index widths for ships and slots
//   XOFF, YOFF         - offset from ship origin to missile spawn point
//   SPEED, YMAX        - missile fall speed per frame and retire line
//   COOLDOWN           - frames a ship is held off after firing
//   coord_t            - 10-bit screen coordinate
//   emissile_t         - one enemy missile slot (active flag + position)
//   wrap_inc()         - ship index + 1, wrapping at NE
package galaga_lib;

  localparam int NE    = 10;
  localparam int NEM   = 4;
  localparam int NE_W  = $clog2(NE);
  localparam int NEM_W = $clog2(NEM);

  typedef logic [9:0] coord_t;

  localparam coord_t     XOFF     = 10'd15;
  localparam coord_t     YOFF     = 10'd20;
  localparam coord_t     SPEED    = 10'd4;
  localparam coord_t     YMAX     = 10'd480;
  localparam logic [5:0] COOLDOWN = 6'd30;

  typedef struct packed {
    logic   active;
    coord_t x;
    coord_t y;
  } emissile_t;

  // Next ship index after i, wrapping from NE-1 back to 0.
  function automatic logic [NE_W-1:0] wrap_inc(input logic [NE_W-1:0] i);
    return (i == NE_W'(NE - 1)) ? '0 : i + NE_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//
// Returns the first set bit of req, scanning ptr, ptr+1, ... and wrapping
// modulo N. With ptr tied to zero it degenerates to a lowest-index pick.
//
// Ports:
//   req   in  N  request vector
//   ptr   in  W  index that has highest priority this cycle (must be < N)
//   valid out 1  at least one request is set
//   idx   out W  index of the chosen request (0 when valid is low)
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  function automatic logic [W-1:0] wrap(input logic [W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  // Scan from the far end back toward ptr so the candidate nearest ptr is
  // the last one written and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap(ptr, k)]) begin
        valid = 1'b1;
        idx   = wrap(ptr, k);
      end
    end
  end

endmodule

// File: rtl/efire_arbiter.sv
// efire_arbiter: shares the enemy missile slots among the enemy ships.
//
// Each ship's fire request is edge-detected into a one-bit pending flag.
// Every cycle one pending ship is chosen round-robin and, if a slot is free,
// a missile is launched from that ship into the lowest free slot. Live
// missiles fall SPEED pixels per FrameTick until they reach YMAX or are hit.
//
// Optional feature (macro EFIRE_COOLDOWN_EN): per-ship cooldown counter that
// keeps a ship out of arbitration for COOLDOWN frames after each grant while
// still holding its pending request.
//
// Ports:
//   Clk           in  1       system clock
//   Reset         in  1       asynchronous, active-high reset
//   FrameTick     in  1       one-Clk pulse per video frame
//   FireReq       in  NE      per-ship scheduled fire bit (level)
//   EAlive        in  NE      ship alive flags
//   EShipX/Y      in  10xNE   ship positions
//   MissileHit    in  NEM     per-slot hit, retires the slot
//   FireGrant     out NE      one-hot, one-cycle grant pulse
//   MissileActive out NEM     slot live flags
//   MissileX/Y    out 10xNEM  slot positions
module efire_arbiter
  import galaga_lib::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  FrameTick,
  input  logic   [NE-1:0]       FireReq,
  input  logic   [NE-1:0]       EAlive,
  input  coord_t [NE-1:0]       EShipX,
  input  coord_t [NE-1:0]       EShipY,
  input  logic   [NEM-1:0]      MissileHit,
  output logic   [NE-1:0]       FireGrant,
  output logic   [NEM-1:0]      MissileActive,
  output coord_t [NEM-1:0]      MissileX,
  output coord_t [NEM-1:0]      MissileY
);

  logic [NE-1:0]   req_prev_q, req_prev_d;
  logic [NE-1:0]   pending_q, pending_d;
  logic [NE-1:0]   grant_q, grant_d;
  logic [NE_W-1:0] rr_ptr_q, rr_ptr_d;
  emissile_t [NEM-1:0] missile_q, missile_d;

  logic [NE-1:0]        eligible;
  logic [NEM-1:0]       slot_free;
  logic [NEM-1:0][10:0] y_sum;
  logic                 win_valid, slot_valid, launch;
  logic [NE_W-1:0]      win_idx;
  logic [NEM_W-1:0]     slot_idx;

`ifdef EFIRE_COOLDOWN_EN
  logic [NE-1:0][5:0] cool_q, cool_d;

  // Ships still cooling down keep their pending bit but sit out arbitration.
  always_comb begin
    for (int i = 0; i < NE; i++) begin
      eligible[i] = pending_q[i] & (cool_q[i] == 6'd0);
    end
  end

  // A grant reloads the counter; otherwise it counts frames down to zero.
  always_comb begin
    for (int i = 0; i < NE; i++) begin
      cool_d[i] = cool_q[i];
      if (grant_d[i]) begin
        cool_d[i] = COOLDOWN;
      end else if (FrameTick && (cool_q[i] != 6'd0)) begin
        cool_d[i] = cool_q[i] - 6'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cool_q <= '0;
    end else begin
      cool_q <= cool_d;
    end
  end
`else
  always_comb begin
    eligible = pending_q;
  end
`endif

  always_comb begin
    for (int s = 0; s < NEM; s++) begin
      slot_free[s] = ~missile_q[s].active;
      y_sum[s]     = {1'b0, missile_q[s].y} + {1'b0, SPEED};
    end
  end

  rr_pick #(.N(NE), .W(NE_W)) u_win_pick (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Fixed-priority use of the same picker: lowest free slot.
  rr_pick #(.N(NEM), .W(NEM_W)) u_slot_pick (
    .req   (slot_free),
    .ptr   ({NEM_W{1'b0}}),
    .valid (slot_valid),
    .idx   (slot_idx)
  );

  assign launch = win_valid & slot_valid;

  // Grant, round-robin pointer and pending bits. Death overrides everything,
  // and a ship being granted drops its pending bit even if a fresh edge
  // arrives at the same time.
  always_comb begin
    req_prev_d = FireReq;
    grant_d    = '0;
    rr_ptr_d   = rr_ptr_q;
    if (launch) begin
      grant_d[win_idx] = 1'b1;
      rr_ptr_d         = wrap_inc(win_idx);
    end
    for (int i = 0; i < NE; i++) begin
      pending_d[i] = pending_q[i];
      if (!EAlive[i]) begin
        pending_d[i] = 1'b0;
      end else if (grant_d[i]) begin
        pending_d[i] = 1'b0;
      end else if (FireReq[i] && !req_prev_q[i]) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  // Missile slots. The launch slot is inactive by construction, so a hit
  // or frame tick aimed at it this cycle has nothing to act on.
  always_comb begin
    missile_d = missile_q;
    for (int s = 0; s < NEM; s++) begin
      if (launch && (slot_idx == NEM_W'(s))) begin
        missile_d[s].active = 1'b1;
        missile_d[s].x      = EShipX[win_idx] + XOFF;
        missile_d[s].y      = EShipY[win_idx] + YOFF;
      end else if (MissileHit[s]) begin
        missile_d[s].active = 1'b0;
      end else if (FrameTick && missile_q[s].active) begin
        if (y_sum[s] >= {1'b0, YMAX}) begin
          missile_d[s].active = 1'b0;
        end else begin
          missile_d[s].y = y_sum[s][9:0];
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      req_prev_q <= '0;
      pending_q  <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      missile_q  <= '0;
    end else begin
      req_prev_q <= req_prev_d;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      missile_q  <= missile_d;
    end
  end

  always_comb begin
    FireGrant = grant_q;
    for (int s = 0; s < NEM; s++) begin
      MissileActive[s] = missile_q[s].active;
      MissileX[s]      = missile_q[s].x;
      MissileY[s]      = missile_q[s].y;
    end
  end

endmodule

// File: tb/tb_efire_arbiter.sv
// tb_efire_arbiter: self-checking bench for efire_arbiter.
// Directed table of per-cycle vectors, a few hand-written corner sequences,
// then randomized traffic compared against a behavioural model.
module tb_efire_arbiter;
  import galaga_lib::*;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 FrameTick;
  logic [NE-1:0]        FireReq;
  logic [NE-1:0]        EAlive;
  logic [NE-1:0][9:0]   EShipX;
  logic [NE-1:0][9:0]   EShipY;
  logic [NEM-1:0]       MissileHit;
  logic [NE-1:0]        FireGrant;
  logic [NEM-1:0]       MissileActive;
  logic [NEM-1:0][9:0]  MissileX;
  logic [NEM-1:0][9:0]  MissileY;

  int checks = 0;
  int errors = 0;

  efire_arbiter dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .FrameTick     (FrameTick),
    .FireReq       (FireReq),
    .EAlive        (EAlive),
    .EShipX        (EShipX),
    .EShipY        (EShipY),
    .MissileHit    (MissileHit),
    .FireGrant     (FireGrant),
    .MissileActive (MissileActive),
    .MissileX      (MissileX),
    .MissileY      (MissileY)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: whole-ship / whole-slot rules using plain integers.
  bit [NE-1:0]  mPend, mPrev, mGrant;
  bit [NEM-1:0] mAct;
  int           mPtr;
  int           mX[NEM], mY[NEM], mCool[NE];
  int           win, slot, ysum;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mPend = '0; mPrev = '0; mGrant = '0; mAct = '0; mPtr = 0;
      for (int s = 0; s < NEM; s++) begin mX[s] = 0; mY[s] = 0; end
      for (int i = 0; i < NE; i++) mCool[i] = 0;
    end else begin
      win = -1; slot = -1;
      for (int s = 0; s < NEM; s++) if (!mAct[s] && slot < 0) slot = s;
      if (slot >= 0)
        for (int k = 0; k < NE; k++)
          if (win < 0 && mPend[(mPtr + k) % NE] && mCool[(mPtr + k) % NE] == 0)
            win = (mPtr + k) % NE;
      for (int s = 0; s < NEM; s++) begin
        if (win >= 0 && s == slot) begin
          mAct[s] = 1'b1;
          mX[s] = (int'(EShipX[win]) + 15) % 1024;
          mY[s] = (int'(EShipY[win]) + 20) % 1024;
        end else if (MissileHit[s]) begin
          mAct[s] = 1'b0;
        end else if (FrameTick && mAct[s]) begin
          ysum = mY[s] + 4;
          if (ysum >= 480) mAct[s] = 1'b0;
          else mY[s] = ysum;
        end
      end
      mGrant = '0;
      for (int i = 0; i < NE; i++) begin
`ifdef EFIRE_COOLDOWN_EN
        if (i == win) mCool[i] = 30;
        else if (FrameTick && mCool[i] > 0) mCool[i] = mCool[i] - 1;
`endif
        if (i == win) mPend[i] = 1'b0;
        else if (FireReq[i] && !mPrev[i] && EAlive[i]) mPend[i] = 1'b1;
        if (!EAlive[i]) mPend[i] = 1'b0;
      end
      mPrev = FireReq;
      if (win >= 0) begin
        mGrant[win] = 1'b1;
        mPtr = (win + 1) % NE;
      end
    end
  end

  typedef struct packed {
    logic [NE-1:0]  req;
    logic [NE-1:0]  alive;
    logic [NEM-1:0] hit;
    logic           tick;
    logic [NE-1:0]  expGrant;
    logic [NEM-1:0] expActive;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [NE-1:0] req, input logic [NE-1:0] alive,
                              input logic [NEM-1:0] hit, input logic [NE-1:0] g,
                              input logic [NEM-1:0] a);
    vec_t v;
    v.req = req; v.alive = alive; v.hit = hit; v.tick = 1'b0;
    v.expGrant = g; v.expActive = a;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the clock edge.
  task automatic applyStimulus(input logic [NE-1:0] req, input logic [NE-1:0] alive,
                               input logic [NEM-1:0] hit, input logic tick);
    FireReq = req; EAlive = alive; MissileHit = hit; FrameTick = tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset();
    FireReq = '0; EAlive = '1; MissileHit = '0; FrameTick = 1'b0;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; FrameTick = 1'b0; FireReq = '0; EAlive = '1; MissileHit = '0;
    for (int i = 0; i < NE; i++) begin
      EShipX[i] = 10'(50 * i + 50);
      EShipY[i] = 10'(10 * i + 10);
    end
    #1;
    checkOutput("reset_grant", 32'(FireGrant), 32'd0);
    checkOutput("reset_active", 32'(MissileActive), 32'd0);
    checkOutput("reset_x", 32'(MissileX), 32'd0);
    checkOutput("reset_y", 32'(MissileY), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // Single fire, round robin from ptr 6, full pool, hit refill, death.
    vecs.push_back(mk(10'h000, 10'h3FF, 4'h0, 10'h000, 4'h0));
    vecs.push_back(mk(10'h008, 10'h3FF, 4'h0, 10'h000, 4'h0));
    vecs.push_back(mk(10'h008, 10'h3FF, 4'h0, 10'h008, 4'h1));
    vecs.push_back(mk(10'h008, 10'h3FF, 4'h0, 10'h000, 4'h1));
    vecs.push_back(mk(10'h000, 10'h3FF, 4'h0, 10'h000, 4'h1));
    vecs.push_back(mk(10'h020, 10'h3FF, 4'h0, 10'h000, 4'h1));
    vecs.push_back(mk(10'h020, 10'h3FF, 4'h0, 10'h020, 4'h3));
    vecs.push_back(mk(10'h000, 10'h3FF, 4'h3, 10'h000, 4'h0));
    vecs.push_back(mk(10'h122, 10'h3FF, 4'h0, 10'h000, 4'h0));
    vecs.push_back(mk(10'h122, 10'h3FF, 4'h0, 10'h100, 4'h1));
    vecs.push_back(mk(10'h122, 10'h3FF, 4'h0, 10'h002, 4'h3));
    vecs.push_back(mk(10'h122, 10'h3FF, 4'h0, 10'h020, 4'h7));
    vecs.push_back(mk(10'h000, 10'h3FF, 4'h0, 10'h000, 4'h7));
    vecs.push_back(mk(10'h000, 10'h3FF, 4'h7, 10'h000, 4'h0));
    vecs.push_back(mk(10'h0FC, 10'h3FF, 4'h0, 10'h000, 4'h0));
    vecs.push_back(mk(10'h0FC, 10'h3FF, 4'h0, 10'h040, 4'h1));
    vecs.push_back(mk(10'h0FC, 10'h3FF, 4'h0, 10'h080, 4'h3));
    vecs.push_back(mk(10'h0FC, 10'h3FF, 4'h0, 10'h004, 4'h7));
    vecs.push_back(mk(10'h0FC, 10'h3FF, 4'h0, 10'h008, 4'hF));
    vecs.push_back(mk(10'h0FC, 10'h3FF, 4'h0, 10'h000, 4'hF));
    vecs.push_back(mk(10'h0FC, 10'h3FF, 4'h4, 10'h000, 4'hB));
    vecs.push_back(mk(10'h0FC, 10'h3FF, 4'h0, 10'h010, 4'hF));
    vecs.push_back(mk(10'h0FC, 10'h3FF, 4'h0, 10'h000, 4'hF));
    vecs.push_back(mk(10'h0FC, 10'h3DF, 4'h0, 10'h000, 4'hF));
    vecs.push_back(mk(10'h0FC, 10'h3DF, 4'h1, 10'h000, 4'hE));
    vecs.push_back(mk(10'h0FC, 10'h3DF, 4'h0, 10'h000, 4'hE));
    vecs.push_back(mk(10'h000, 10'h3FF, 4'h0, 10'h000, 4'hE));
    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].req, vecs[v].alive, vecs[v].hit, vecs[v].tick);
      checkOutput($sformatf("vec%0d_grant", v), 32'(FireGrant), 32'(vecs[v].expGrant));
      checkOutput($sformatf("vec%0d_active", v), 32'(MissileActive), 32'(vecs[v].expActive));
    end

    // Asynchronous reset with three live missiles, between clock edges.
    #3 Reset = 1'b1;
    #1;
    checkOutput("async_reset_active", 32'(MissileActive), 32'd0);
    checkOutput("async_reset_x", 32'(MissileX), 32'd0);
    checkOutput("async_reset_y", 32'(MissileY), 32'd0);
    @(posedge Clk); #1;
    doReset();

    // Spawn offsets, fall to the bottom line, and coordinate wrap.
    EShipY[0] = 10'd452;
    applyStimulus(10'h008, '1, 4'h0, 1'b0);
    applyStimulus(10'h008, '1, 4'h0, 1'b0);
    checkOutput("fire3_grant", 32'(FireGrant), 32'h008);
    checkOutput("fire3_x", 32'(MissileX[0]), 32'd215);
    checkOutput("fire3_y", 32'(MissileY[0]), 32'd60);
    applyStimulus(10'h009, '1, 4'h0, 1'b0);
    applyStimulus(10'h009, '1, 4'h0, 1'b0);
    checkOutput("fire0_grant", 32'(FireGrant), 32'h001);
    checkOutput("fire0_y", 32'(MissileY[1]), 32'd472);
    applyStimulus(10'h009, '1, 4'h0, 1'b1);
    checkOutput("tick1_y", 32'(MissileY[1]), 32'd476);
    checkOutput("tick1_active", 32'(MissileActive), 32'h3);
    checkOutput("tick1_slot0_y", 32'(MissileY[0]), 32'd64);
    applyStimulus(10'h009, '1, 4'h0, 1'b1);
    checkOutput("tick2_retire", 32'(MissileActive), 32'h1);
    EShipX[9] = 10'd1020; EShipY[9] = 10'd1010;
    applyStimulus(10'h209, '1, 4'h0, 1'b0);
    applyStimulus(10'h209, '1, 4'h0, 1'b0);
    checkOutput("wrap_grant", 32'(FireGrant), 32'h200);
    checkOutput("wrap_x", 32'(MissileX[1]), 32'd11);
    checkOutput("wrap_y", 32'(MissileY[1]), 32'd6);
    doReset();

`ifdef EFIRE_COOLDOWN_EN
    applyStimulus(10'h004, '1, 4'h0, 1'b0);
    applyStimulus(10'h004, '1, 4'h0, 1'b0);
    checkOutput("cool_first_grant", 32'(FireGrant), 32'h004);
    for (int n = 1; n <= 30; n++) begin
      for (int c = 0; c < 4; c++) begin
        applyStimulus((n >= 5) ? 10'h004 : 10'h000, '1, 4'h0, (c == 3));
        checkOutput($sformatf("cool_blocked_f%0d", n), 32'(FireGrant), 32'h0);
      end
    end
    applyStimulus(10'h004, '1, 4'h0, 1'b0);
    checkOutput("cool_release_grant", 32'(FireGrant), 32'h004);
    doReset();
`endif

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < NE; i++) begin
        EShipX[i] = 10'($urandom_range(0, 1023));
        EShipY[i] = 10'($urandom_range(0, 470));
      end
      applyStimulus(FireReq ^ NE'($urandom & $urandom),
                    ~NE'($urandom & $urandom & $urandom & $urandom),
                    NEM'($urandom & $urandom & $urandom & $urandom),
                    ($urandom_range(0, 3) == 0));
      checkOutput($sformatf("rand%0d_grant", cyc), 32'(FireGrant), 32'(mGrant));
      checkOutput($sformatf("rand%0d_active", cyc), 32'(MissileActive), 32'(mAct));
      for (int s = 0; s < NEM; s++) begin
        if (mAct[s]) begin
          checkOutput($sformatf("rand%0d_x%0d", cyc, s), 32'(MissileX[s]), 32'(mX[s]));
          checkOutput($sformatf("rand%0d_y%0d", cyc, s), 32'(MissileY[s]), 32'(mY[s]));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
